game_sequencer: RTL and testbench

- Top-level game-flow controller for the Pac-Man core. Sits beside the map/candy BRAM, movement and sprite blocks.
- Sequences the game through start, ready, play, death, level-clear and game-over phases, and tracks lives, level and remaining candies.
- Requests a map BRAM reload before each level and gates entity movement.
- Runs frightened-mode timing after power cookies and classifies pacman/enemy collisions as either death or ghost eaten.

---
 rtl/game_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_game_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_sequencer.sv
// game_sequencer: game-flow controller for the Pac-Man core.
// Sequences start, reload, ready, play, death, level-clear and game-over
// phases. It also tracks lives, level, remaining candies and frightened-mode
// timing, and classifies pacman/enemy collisions.
module game_sequencer #(
    parameter int TOTAL_CANDIES = 244,
    parameter int START_LIVES   = 3,
    parameter int READY_FRAMES  = 120,
    parameter int DEATH_FRAMES  = 90,
    parameter int CLEAR_FRAMES  = 120,
    parameter int FRIGHT_FRAMES = 360,
    parameter int FRIGHT_WARN   = 120
) (
    input  logic       vga_pix_clk,
    input  logic       rst_n,
    input  logic       frame_stb,
    input  logic       start_btn,
    input  logic       ate_candy_stb,
    input  logic       ate_power_cookie_stb,
    input  logic       collided_with_enemy,
    input  logic       map_reload_done,
    output logic [2:0] state,
    output logic       movement_en,
    output logic       entities_rst,
    output logic       map_reload_req,
    output logic       frightened,
    output logic       fright_ending,
    output logic       ghost_eaten_stb,
    output logic [1:0] lives,
    output logic [3:0] level,
    output logic [8:0] candies_left
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_READY  = 3'd1;
    localparam logic [2:0] S_PLAY   = 3'd2;
    localparam logic [2:0] S_DEATH  = 3'd3;
    localparam logic [2:0] S_CLEAR  = 3'd4;
    localparam logic [2:0] S_OVER   = 3'd5;
    localparam logic [2:0] S_RELOAD = 3'd6;

    logic [2:0]  state_nxt;
    logic [1:0]  lives_nxt;
    logic [3:0]  level_nxt;
    logic [8:0]  candies_nxt;
    logic [15:0] frame_cnt;
    logic [15:0] frame_cnt_nxt;
    logic [15:0] fright_tmr;
    logic [15:0] fright_nxt;
    logic        coll_q;
    logic        coll_edge;
    logic        ghost_nxt;
    logic        timed_state;
    logic [15:0] frame_limit;
    logic        frame_done;
    logic [1:0]  eat_cnt;
    logic [8:0]  candies_dec;

    // Next-state, counters and event classification for the whole game flow.
    always_comb begin
        state_nxt     = state;
        lives_nxt     = lives;
        level_nxt     = level;
        candies_nxt   = candies_left;
        fright_nxt    = fright_tmr;
        ghost_nxt     = 1'b0;
        frame_cnt_nxt = frame_cnt;

        coll_edge = collided_with_enemy & ~coll_q;

        // Only READY, DEATH and CLEAR are timed by frames.
        timed_state = 1'b0;
        frame_limit = 16'd0;
        case (state)
            S_READY: begin
                timed_state = 1'b1;
                frame_limit = 16'(READY_FRAMES - 1);
            end
            S_DEATH: begin
                timed_state = 1'b1;
                frame_limit = 16'(DEATH_FRAMES - 1);
            end
            S_CLEAR: begin
                timed_state = 1'b1;
                frame_limit = 16'(CLEAR_FRAMES - 1);
            end
            default: begin
                timed_state = 1'b0;
                frame_limit = 16'd0;
            end
        endcase
        frame_done = timed_state && frame_stb && (frame_cnt == frame_limit);

        // Candy and power cookie in the same cycle remove two edibles.
        eat_cnt     = {1'b0, ate_candy_stb} + {1'b0, ate_power_cookie_stb};
        candies_dec = (candies_left > {7'd0, eat_cnt}) ?
                      (candies_left - {7'd0, eat_cnt}) : 9'd0;

        case (state)
            S_IDLE, S_OVER: begin
                if (start_btn) begin
                    lives_nxt   = 2'(START_LIVES);
                    level_nxt   = 4'd0;
                    candies_nxt = 9'(TOTAL_CANDIES);
                    state_nxt   = S_RELOAD;
                end
            end
            S_RELOAD: begin
                if (map_reload_done) begin
                    state_nxt = S_READY;
                end
            end
            S_READY: begin
                if (frame_done) begin
                    state_nxt = S_PLAY;
                end
            end
            S_PLAY: begin
                candies_nxt = candies_dec;
                // A new cookie restarts the timer, taking priority over decay.
                if (ate_power_cookie_stb) begin
                    fright_nxt = 16'(FRIGHT_FRAMES);
                end else if (frame_stb && (fright_tmr != 16'd0)) begin
                    fright_nxt = fright_tmr - 16'd1;
                end
                if (coll_edge && (fright_tmr != 16'd0)) begin
                    ghost_nxt = 1'b1;
                end
                // Clearing the level beats a lethal collision in the same cycle.
                if (candies_dec == 9'd0) begin
                    state_nxt = S_CLEAR;
                end else if (coll_edge && (fright_tmr == 16'd0)) begin
                    state_nxt = S_DEATH;
                end
            end
            S_DEATH: begin
                if (frame_done) begin
                    if (lives == 2'd1) begin
                        lives_nxt = 2'd0;
                        state_nxt = S_OVER;
                    end else begin
                        lives_nxt = lives - 2'd1;
                        state_nxt = S_READY;
                    end
                end
            end
            S_CLEAR: begin
                if (frame_done) begin
                    level_nxt   = (level == 4'd15) ? 4'd15 : level + 4'd1;
                    candies_nxt = 9'(TOTAL_CANDIES);
                    state_nxt   = S_RELOAD;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // Leaving PLAY for death or clear always ends frightened mode.
        if ((state_nxt == S_DEATH) || (state_nxt == S_CLEAR)) begin
            fright_nxt = 16'd0;
        end

        if (state_nxt != state) begin
            frame_cnt_nxt = 16'd0;
        end else if (timed_state && frame_stb) begin
            frame_cnt_nxt = frame_cnt + 16'd1;
        end
    end

    // Register state, counters and all outputs so every output is glitch-free.
    always_ff @(posedge vga_pix_clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            lives           <= 2'(START_LIVES);
            level           <= 4'd0;
            candies_left    <= 9'(TOTAL_CANDIES);
            frame_cnt       <= 16'd0;
            fright_tmr      <= 16'd0;
            coll_q          <= 1'b0;
            movement_en     <= 1'b0;
            entities_rst    <= 1'b0;
            map_reload_req  <= 1'b0;
            frightened      <= 1'b0;
            fright_ending   <= 1'b0;
            ghost_eaten_stb <= 1'b0;
        end else begin
            state           <= state_nxt;
            lives           <= lives_nxt;
            level           <= level_nxt;
            candies_left    <= candies_nxt;
            frame_cnt       <= frame_cnt_nxt;
            fright_tmr      <= fright_nxt;
            coll_q          <= collided_with_enemy;
            movement_en     <= (state_nxt == S_PLAY);
            entities_rst    <= (state_nxt == S_READY) && (state != S_READY);
            map_reload_req  <= (state_nxt == S_RELOAD);
            frightened      <= (fright_nxt != 16'd0);
            fright_ending   <= (fright_nxt != 16'd0) &&
                               (fright_nxt <= 16'(FRIGHT_WARN));
            ghost_eaten_stb <= ghost_nxt;
        end
    end

endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: directed vectors and hand-written sequences for
// game_sequencer using the default parameter set.
module tb_game_sequencer;

    logic       vga_pix_clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_stb = 1'b0;
    logic       start_btn = 1'b0;
    logic       ate_candy_stb = 1'b0;
    logic       ate_power_cookie_stb = 1'b0;
    logic       collided_with_enemy = 1'b0;
    logic       map_reload_done = 1'b0;
    logic [2:0] state;
    logic       movement_en;
    logic       entities_rst;
    logic       map_reload_req;
    logic       frightened;
    logic       fright_ending;
    logic       ghost_eaten_stb;
    logic [1:0] lives;
    logic [3:0] level;
    logic [8:0] candies_left;

    int n_pass = 0;
    int n_total = 0;

    game_sequencer dut (
        .vga_pix_clk          (vga_pix_clk),
        .rst_n                (rst_n),
        .frame_stb            (frame_stb),
        .start_btn            (start_btn),
        .ate_candy_stb        (ate_candy_stb),
        .ate_power_cookie_stb (ate_power_cookie_stb),
        .collided_with_enemy  (collided_with_enemy),
        .map_reload_done      (map_reload_done),
        .state                (state),
        .movement_en          (movement_en),
        .entities_rst         (entities_rst),
        .map_reload_req       (map_reload_req),
        .frightened           (frightened),
        .fright_ending        (fright_ending),
        .ghost_eaten_stb      (ghost_eaten_stb),
        .lives                (lives),
        .level                (level),
        .candies_left         (candies_left)
    );

    always #5 vga_pix_clk = ~vga_pix_clk;

    typedef struct {
        logic frame;
        logic candy;
        logic power;
        logic coll;
        logic done;
        int   exp_state;
        int   exp_candies;
        int   exp_fr;
        int   exp_fe;
        int   exp_ghost;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge vga_pix_clk);
        #1;
    endtask

    // Each frame: one idle cycle, then a frame_stb cycle; returns just after it.
    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            frame_stb = 1'b1;
            tick();
            frame_stb = 1'b0;
        end
    endtask

    task automatic pulse_start();
        start_btn = 1'b1;
        tick();
        start_btn = 1'b0;
    endtask

    task automatic pulse_done();
        map_reload_done = 1'b1;
        tick();
        map_reload_done = 1'b0;
    endtask

    task automatic eat_candies(input int n);
        ate_candy_stb = 1'b1;
        for (int i = 0; i < n; i++) tick();
        ate_candy_stb = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int ghosts;
        vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2, 243, 0, 0, 0};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2, 242, 1, 0, 0};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2, 240, 1, 0, 0};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2, 240, 1, 0, 1};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2, 240, 1, 0, 0};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2, 240, 1, 0, 0};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2, 240, 1, 0, 0};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2, 240, 1, 0, 0};

        // Reset values
        #12;
        check("rst_state", state, 0);
        check("rst_lives", lives, 3);
        check("rst_level", level, 0);
        check("rst_candies", candies_left, 244);
        check("rst_req", map_reload_req, 0);
        check("rst_move", movement_en, 0);
        rst_n = 1'b1;
        tick();

        // Start, reload, ready
        pulse_start();
        check("start_state", state, 6);
        check("start_req", map_reload_req, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("reload_req_hold", map_reload_req, 1);
        end
        pulse_done();
        check("ready_state", state, 1);
        check("ready_req", map_reload_req, 0);
        check("ready_ent_rst", entities_rst, 1);
        check("ready_move", movement_en, 0);
        tick();
        check("ready_ent_rst_once", entities_rst, 0);
        frames(119);
        check("ready_119", state, 1);
        frames(1);
        check("play_state", state, 2);
        check("play_move", movement_en, 1);

        // Table of single-cycle PLAY events
        for (int v = 0; v < 8; v++) begin
            frame_stb            = vecs[v].frame;
            ate_candy_stb        = vecs[v].candy;
            ate_power_cookie_stb = vecs[v].power;
            collided_with_enemy  = vecs[v].coll;
            map_reload_done      = vecs[v].done;
            tick();
            frame_stb = 1'b0; ate_candy_stb = 1'b0; ate_power_cookie_stb = 1'b0;
            map_reload_done = 1'b0;
            check($sformatf("vec%0d_state", v), state, vecs[v].exp_state);
            check($sformatf("vec%0d_candies", v), candies_left, vecs[v].exp_candies);
            check($sformatf("vec%0d_fr", v), frightened, vecs[v].exp_fr);
            check($sformatf("vec%0d_fe", v), fright_ending, vecs[v].exp_fe);
            check($sformatf("vec%0d_ghost", v), ghost_eaten_stb, vecs[v].exp_ghost);
        end

        // Frightened timing from a fresh cookie (timer 360)
        ate_power_cookie_stb = 1'b1; tick(); ate_power_cookie_stb = 1'b0;
        check("cookie_candies", candies_left, 239);
        frames(239);
        check("t121_fr", frightened, 1);
        check("t121_fe", fright_ending, 0);
        frames(1);
        check("t120_fe", fright_ending, 1);
        frames(120);
        check("t0_fr", frightened, 0);
        check("t0_fe", fright_ending, 0);

        // Cookie restart at frame 300
        ate_power_cookie_stb = 1'b1; tick(); ate_power_cookie_stb = 1'b0;
        frames(300);
        check("t60_fe", fright_ending, 1);
        ate_power_cookie_stb = 1'b1; tick(); ate_power_cookie_stb = 1'b0;
        check("restart_fr", frightened, 1);
        check("restart_fe", fright_ending, 0);
        check("restart_candies", candies_left, 237);

        // Held collision while frightened: exactly one ghost eaten
        ghosts = 0;
        collided_with_enemy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            ghosts += int'(ghost_eaten_stb);
        end
        collided_with_enemy = 1'b0;
        tick();
        check("ghost_count", ghosts, 1);
        check("ghost_state", state, 2);
        frames(359);
        check("restart_t1_fr", frightened, 1);
        frames(1);
        check("restart_t0_fr", frightened, 0);

        // Held collision while not frightened: one death
        ghosts = 0;
        collided_with_enemy = 1'b1;
        tick();
        check("death_state", state, 3);
        check("death_move", movement_en, 0);
        for (int i = 0; i < 9; i++) begin
            tick();
            ghosts += int'(ghost_eaten_stb);
        end
        collided_with_enemy = 1'b0;
        check("death_no_ghost", ghosts, 0);
        frames(89);
        check("death_89", state, 3);
        check("death_lives_hold", lives, 3);
        frames(1);
        check("respawn_state", state, 1);
        check("respawn_lives", lives, 2);
        check("respawn_ent_rst", entities_rst, 1);
        frames(120);
        check("replay_state", state, 2);

        // Level clear with the last edible being a power cookie
        eat_candies(236);
        check("one_left", candies_left, 1);
        check("one_left_state", state, 2);
        ate_power_cookie_stb = 1'b1; tick(); ate_power_cookie_stb = 1'b0;
        check("clear_state", state, 4);
        check("clear_candies", candies_left, 0);
        check("clear_fr", frightened, 0);
        frames(119);
        check("clear_119", state, 4);
        frames(1);
        check("clear_reload", state, 6);
        check("clear_level", level, 1);
        check("clear_refill", candies_left, 244);
        check("clear_req", map_reload_req, 1);
        pulse_done();
        frames(120);
        check("lvl1_play", state, 2);

        // Remaining lives lost: 2 -> 1 -> 0, then game over
        for (int d = 0; d < 2; d++) begin
            collided_with_enemy = 1'b1; tick(); collided_with_enemy = 1'b0;
            check($sformatf("die%0d_state", d), state, 3);
            frames(90);
            if (d == 0) begin
                check("die0_lives", lives, 1);
                check("die0_ready", state, 1);
                frames(120);
            end
        end
        check("over_state", state, 5);
        check("over_lives", lives, 0);
        check("over_move", movement_en, 0);
        pulse_start();
        check("restart_state", state, 6);
        check("restart_lives", lives, 3);
        check("restart_level", level, 0);
        check("restart_refill", candies_left, 244);

        // Asynchronous reset in the middle of RELOAD
        tick();
        @(posedge vga_pix_clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_state", state, 0);
        check("async_req", map_reload_req, 0);
        #1;
        rst_n = 1'b1;
        tick();

        // Last candy and lethal collision in the same cycle: clear wins
        pulse_start();
        pulse_done();
        frames(120);
        check("final_play", state, 2);
        eat_candies(243);
        check("final_one_left", candies_left, 1);
        ate_candy_stb = 1'b1;
        collided_with_enemy = 1'b1;
        tick();
        ate_candy_stb = 1'b0;
        collided_with_enemy = 1'b0;
        check("tie_state", state, 4);
        check("tie_lives", lives, 3);
        check("tie_candies", candies_left, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
